// File: rtl/agex_mdu_stage_if.sv
// Handshake and datapath bundle for the execute stage.
// master: decode/memory side (drives operands and out_ready).
// slave:  the execute stage itself.
interface agex_mdu_stage_if #(
    parameter int XLEN      = 32,
    parameter int REGNOBITS = 5
);
    logic                 in_valid;
    logic                 in_ready;
    logic [4:0]           in_op;
    logic [XLEN-1:0]      in_a;
    logic [XLEN-1:0]      in_b;
    logic [XLEN-1:0]      in_rs2;
    logic [XLEN-1:0]      in_imm;
    logic [XLEN-1:0]      in_pc;
    logic [REGNOBITS-1:0] in_rd;
    logic                 in_wr_reg;

    logic                 out_valid;
    logic                 out_ready;
    logic [XLEN-1:0]      out_result;
    logic [REGNOBITS-1:0] out_rd;
    logic                 out_wr_reg;
    logic                 out_illegal;
    logic                 br_taken;
    logic [XLEN-1:0]      br_target;
    logic                 busy;

    modport master (
        output in_valid, in_op, in_a, in_b, in_rs2, in_imm, in_pc, in_rd, in_wr_reg,
        output out_ready,
        input  in_ready, out_valid, out_result, out_rd, out_wr_reg, out_illegal,
        input  br_taken, br_target, busy
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_rs2, in_imm, in_pc, in_rd, in_wr_reg,
        input  out_ready,
        output in_ready, out_valid, out_result, out_rd, out_wr_reg, out_illegal,
        output br_taken, br_target, busy
    );
endinterface

// File: rtl/agex_mdu_stage.sv
// Execute stage: single-cycle ALU and branch resolver plus an optional
// iterative multiply/divide unit, with valid/ready on both sides.
// Build macro AGEX_MDU_EN includes the MDU; without it ops 10-15 are
// reported illegal and busy stays low.
module agex_mdu_stage #(
    parameter int XLEN      = 32,
    parameter int REGNOBITS = 5,
    parameter int CNTBITS   = 6
) (
    input logic             clk,
    input logic             reset,
    agex_mdu_stage_if.slave bus
);
    localparam int SHW = $clog2(XLEN);

    localparam logic [4:0] OP_ADD   = 5'd0;
    localparam logic [4:0] OP_SUB   = 5'd1;
    localparam logic [4:0] OP_AND   = 5'd2;
    localparam logic [4:0] OP_OR    = 5'd3;
    localparam logic [4:0] OP_XOR   = 5'd4;
    localparam logic [4:0] OP_SLL   = 5'd5;
    localparam logic [4:0] OP_SRL   = 5'd6;
    localparam logic [4:0] OP_SRA   = 5'd7;
    localparam logic [4:0] OP_SLT   = 5'd8;
    localparam logic [4:0] OP_SLTU  = 5'd9;
    localparam logic [4:0] OP_MUL   = 5'd10;
    localparam logic [4:0] OP_MULHU = 5'd11;
    localparam logic [4:0] OP_DIV   = 5'd12;
    localparam logic [4:0] OP_DIVU  = 5'd13;
    localparam logic [4:0] OP_REM   = 5'd14;
    localparam logic [4:0] OP_REMU  = 5'd15;
    localparam logic [4:0] OP_BEQ   = 5'd16;
    localparam logic [4:0] OP_BNE   = 5'd17;
    localparam logic [4:0] OP_BLT   = 5'd18;
    localparam logic [4:0] OP_BGE   = 5'd19;
    localparam logic [4:0] OP_BLTU  = 5'd20;
    localparam logic [4:0] OP_BGEU  = 5'd21;
    localparam logic [4:0] OP_JAL   = 5'd22;
    localparam logic [4:0] OP_JALR  = 5'd23;

    typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

    state_t state, state_nxt;

    logic [XLEN-1:0] a, b, rs2, imm, pc;
    assign a   = bus.in_a;
    assign b   = bus.in_b;
    assign rs2 = bus.in_rs2;
    assign imm = bus.in_imm;
    assign pc  = bus.in_pc;

    logic [SHW-1:0] shamt;
    assign shamt = b[SHW-1:0];

    // Registered outputs
    logic                 out_valid_q;
    logic [XLEN-1:0]      out_result_q;
    logic [REGNOBITS-1:0] out_rd_q;
    logic                 out_wr_q;
    logic                 out_illegal_q;
    logic                 br_taken_q;
    logic [XLEN-1:0]      br_target_q;

    logic in_ready_c, busy_c, accept, mdu_last;

    // Single-cycle decode results
    logic [XLEN-1:0] res_result, res_target;
    logic            res_illegal, res_wr, res_taken, res_mdu;

    // ALU, branch resolver and op classification for the presented instruction
    always_comb begin
        res_result  = '0;
        res_target  = '0;
        res_illegal = 1'b0;
        res_wr      = bus.in_wr_reg;
        res_taken   = 1'b0;
        res_mdu     = 1'b0;
        case (bus.in_op)
            OP_ADD:  res_result = a + b;
            OP_SUB:  res_result = a - b;
            OP_AND:  res_result = a & b;
            OP_OR:   res_result = a | b;
            OP_XOR:  res_result = a ^ b;
            OP_SLL:  res_result = a << shamt;
            OP_SRL:  res_result = a >> shamt;
            OP_SRA:  res_result = $signed(a) >>> shamt;
            OP_SLT:  res_result = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU: res_result = {{(XLEN-1){1'b0}}, a < b};
            OP_MUL, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU: begin
`ifdef AGEX_MDU_EN
                res_mdu     = 1'b1;
`else
                res_illegal = 1'b1;
                res_wr      = 1'b0;
`endif
            end
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
                // Branches never write rd; only the redirect matters.
                res_wr     = 1'b0;
                res_target = pc + imm;
                case (bus.in_op)
                    OP_BEQ:  res_taken = (a == rs2);
                    OP_BNE:  res_taken = (a != rs2);
                    OP_BLT:  res_taken = ($signed(a) < $signed(rs2));
                    OP_BGE:  res_taken = ($signed(a) >= $signed(rs2));
                    OP_BLTU: res_taken = (a < rs2);
                    default: res_taken = (a >= rs2);
                endcase
            end
            OP_JAL: begin
                res_taken  = 1'b1;
                res_target = pc + imm;
                res_result = pc + XLEN'(4);
            end
            OP_JALR: begin
                res_taken  = 1'b1;
                res_target = (a + imm) & ~XLEN'(1);
                res_result = pc + XLEN'(4);
            end
            default: begin
                res_illegal = 1'b1;
                res_wr      = 1'b0;
            end
        endcase
    end

`ifdef AGEX_MDU_EN
    // MDU working registers: {acc_hi, acc_lo} is the product / remainder:quotient pair
    logic [XLEN-1:0]    acc_hi, acc_lo, opnd;
    logic [CNTBITS-1:0] cnt;
    logic [4:0]         mdu_op;
    logic               mdu_is_mul, q_neg, r_neg, div0;

    logic            a_sgn, b_sgn;
    logic [XLEN-1:0] a_mag, b_mag;
    logic [XLEN:0]   mul_sum, div_sh, div_diff;
    logic [XLEN-1:0] step_hi, step_lo, mdu_result;

    // Operand magnitudes for the signed divide flavours
    always_comb begin
        a_sgn = ((bus.in_op == OP_DIV) || (bus.in_op == OP_REM)) && a[XLEN-1];
        b_sgn = ((bus.in_op == OP_DIV) || (bus.in_op == OP_REM)) && b[XLEN-1];
        a_mag = a_sgn ? -a : a;
        b_mag = b_sgn ? -b : b;
    end

    // One shift-add or restoring-divide step, and the final result picked from it
    always_comb begin
        mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        div_sh   = {acc_hi, acc_lo[XLEN-1]};
        div_diff = div_sh - {1'b0, opnd};
        if (mdu_is_mul) begin
            step_hi = mul_sum[XLEN:1];
            step_lo = {mul_sum[0], acc_lo[XLEN-1:1]};
        end else if (!div_diff[XLEN]) begin
            step_hi = div_diff[XLEN-1:0];
            step_lo = {acc_lo[XLEN-2:0], 1'b1};
        end else begin
            step_hi = div_sh[XLEN-1:0];
            step_lo = {acc_lo[XLEN-2:0], 1'b0};
        end
        case (mdu_op)
            OP_MUL:          mdu_result = step_lo;
            OP_MULHU:        mdu_result = step_hi;
            OP_DIV, OP_DIVU: mdu_result = div0 ? '1 : (q_neg ? -step_lo : step_lo);
            default:         mdu_result = r_neg ? -step_hi : step_hi;
        endcase
    end

    assign mdu_last = (cnt == CNTBITS'(1));

    // MDU load on accept, iterate while BUSY
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_hi     <= '0;
            acc_lo     <= '0;
            opnd       <= '0;
            cnt        <= '0;
            mdu_op     <= '0;
            mdu_is_mul <= 1'b0;
            q_neg      <= 1'b0;
            r_neg      <= 1'b0;
            div0       <= 1'b0;
        end else if (accept && res_mdu) begin
            mdu_is_mul <= (bus.in_op == OP_MUL) || (bus.in_op == OP_MULHU);
            mdu_op     <= bus.in_op;
            acc_hi     <= '0;
            if ((bus.in_op == OP_MUL) || (bus.in_op == OP_MULHU)) begin
                acc_lo <= b;
                opnd   <= a;
            end else begin
                acc_lo <= a_mag;
                opnd   <= b_mag;
            end
            // Zero divisor: magnitude divide already leaves rem = |a|,
            // and the r_neg fix-up restores the dividend; only q is forced.
            q_neg <= a_sgn ^ b_sgn;
            r_neg <= a_sgn;
            div0  <= (b == '0);
            cnt   <= CNTBITS'(XLEN);
        end else if (state == BUSY) begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
            cnt    <= cnt - CNTBITS'(1);
        end
    end
`else
    assign mdu_last = 1'b0;
`endif

    assign accept = bus.in_valid && in_ready_c;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && res_mdu) state_nxt = BUSY;
            BUSY:    if (mdu_last)          state_nxt = HOLD;
            HOLD:    if (bus.out_ready)     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: upstream ready and the decode stall
    always_comb begin
        in_ready_c = 1'b0;
        busy_c     = 1'b0;
        case (state)
            IDLE: in_ready_c = !out_valid_q || bus.out_ready;
`ifdef AGEX_MDU_EN
            BUSY: busy_c = 1'b1;
`endif
            default: ;
        endcase
    end

    // Output register: capture single-cycle results, MDU completion, handshake drop
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q   <= 1'b0;
            out_result_q  <= '0;
            out_rd_q      <= '0;
            out_wr_q      <= 1'b0;
            out_illegal_q <= 1'b0;
            br_taken_q    <= 1'b0;
            br_target_q   <= '0;
        end else begin
            br_taken_q <= 1'b0;
            if (out_valid_q && bus.out_ready) out_valid_q <= 1'b0;
            if (accept) begin
                out_result_q  <= res_result;
                out_rd_q      <= bus.in_rd;
                out_wr_q      <= res_wr;
                out_illegal_q <= res_illegal;
                br_target_q   <= res_target;
                if (!res_mdu) begin
                    out_valid_q <= 1'b1;
                    br_taken_q  <= res_taken;
                end
            end
`ifdef AGEX_MDU_EN
            if ((state == BUSY) && mdu_last) begin
                out_valid_q  <= 1'b1;
                out_result_q <= mdu_result;
            end
`endif
        end
    end

    assign bus.in_ready    = in_ready_c;
    assign bus.busy        = busy_c;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_result  = out_result_q;
    assign bus.out_rd      = out_rd_q;
    assign bus.out_wr_reg  = out_wr_q;
    assign bus.out_illegal = out_illegal_q;
    assign bus.br_taken    = br_taken_q;
    assign bus.br_target   = br_target_q;
endmodule

// File: tb/tb_agex_mdu_stage.sv
// Directed self-checking bench for agex_mdu_stage (XLEN=32).
// MDU scenarios are compiled in only when AGEX_MDU_EN is defined;
// otherwise the bench checks that ops 10-15 come back illegal.
module tb_agex_mdu_stage;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    agex_mdu_stage_if #(.XLEN(32), .REGNOBITS(5)) bus();

    agex_mdu_stage #(.XLEN(32), .REGNOBITS(5), .CNTBITS(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction for a single edge (caller ensures in_ready=1).
    task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] rs2, input logic [31:0] imm, input logic [31:0] pc,
                        input logic [4:0] rd, input logic wr);
        bus.in_valid  = 1'b1;
        bus.in_op     = op;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_rs2    = rs2;
        bus.in_imm    = imm;
        bus.in_pc     = pc;
        bus.in_rd     = rd;
        bus.in_wr_reg = wr;
        tick();
        bus.in_valid  = 1'b0;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.in_op = '0; bus.in_a = '0; bus.in_b = '0;
        bus.in_rs2 = '0; bus.in_imm = '0; bus.in_pc = '0; bus.in_rd = '0;
        bus.in_wr_reg = 1'b0; bus.out_ready = 1'b0;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.out_result !== 32'h0 || bus.out_rd !== 5'h0 ||
            bus.out_wr_reg !== 1'b0 || bus.out_illegal !== 1'b0 || bus.br_taken !== 1'b0 ||
            bus.br_target !== 32'h0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid=%b res=%h rd=%h wr=%b ill=%b bt=%b tgt=%h busy=%b, required all zero",
                     bus.out_valid, bus.out_result, bus.out_rd, bus.out_wr_reg, bus.out_illegal,
                     bus.br_taken, bus.br_target, bus.busy);
        end
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b required 1", bus.in_ready);
        end
    endtask

    task automatic test_alu();
        logic [4:0]  ops [13] = '{5'd0, 5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd8, 5'd9};
        logic [31:0] av  [13] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 32'd5, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hFFFF0000,
                                  32'h1, 32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 32'h1};
        logic [31:0] bv  [13] = '{32'h1, 32'h1, 32'd7, 32'hFF00FF00, 32'h0F0F0000, 32'hFF00FF00,
                                  32'h3F, 32'h4, 32'h4, 32'h1, 32'h1, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] ex  [13] = '{32'h80000000, 32'h0, 32'hFFFFFFFE, 32'hF000F000, 32'hFFFFF0F0, 32'h00FFFF00,
                                  32'h80000000, 32'h08000000, 32'hF8000000, 32'h1, 32'h0, 32'h0, 32'h1};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            send(ops[i], av[i], bv[i], 32'h5555AAAA, 32'h0, 32'h0, 5'(i + 1), 1'b1);
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_result !== ex[i] || bus.out_rd !== 5'(i + 1) ||
                bus.out_wr_reg !== 1'b1 || bus.out_illegal !== 1'b0 || bus.br_taken !== 1'b0) begin
                n_fail++;
                $display("FAIL alu[%0d] op%0d: valid=%b res=%h rd=%0d wr=%b ill=%b bt=%b, required valid=1 res=%h rd=%0d wr=1 ill=0 bt=0",
                         i, ops[i], bus.out_valid, bus.out_result, bus.out_rd, bus.out_wr_reg,
                         bus.out_illegal, bus.br_taken, ex[i], i + 1);
            end
        end
        tick();
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL alu_valid_drop: got %b required 0", bus.out_valid);
        end
    endtask

    task automatic test_branch();
        logic [4:0]  ops [10] = '{5'd17, 5'd16, 5'd16, 5'd18, 5'd20, 5'd19, 5'd21, 5'd19, 5'd22, 5'd23};
        logic [31:0] av  [10] = '{32'd3, 32'd3, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'd1, 32'd2, 32'h0, 32'h201};
        logic [31:0] rv  [10] = '{32'd4, 32'd4, 32'd5, 32'd1, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'h0, 32'h0};
        logic [31:0] pcv [10] = '{32'h100, 32'h100, 32'h200, 32'h40, 32'h40, 32'h80, 32'h80, 32'h0, 32'h100, 32'h300};
        logic [31:0] imv [10] = '{32'h20, 32'h20, 32'hFFFFFFF8, 32'h10, 32'h10, 32'h4, 32'h4, 32'h10, 32'h40, 32'h0};
        logic        tk  [10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [31:0] tg  [10] = '{32'h120, 32'h0, 32'h1F8, 32'h50, 32'h0, 32'h84, 32'h0, 32'h10, 32'h140, 32'h200};
        logic        wrx [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            // in_b deliberately differs from rs2: compares must use rs2
            send(ops[i], av[i], 32'hDEAD0000, rv[i], imv[i], pcv[i], 5'd9, 1'b1);
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.br_taken !== tk[i] || bus.out_wr_reg !== wrx[i] ||
                (tk[i] && bus.br_target !== tg[i])) begin
                n_fail++;
                $display("FAIL branch[%0d] op%0d: valid=%b bt=%b tgt=%h wr=%b, required valid=1 bt=%b tgt=%h wr=%b",
                         i, ops[i], bus.out_valid, bus.br_taken, bus.br_target, bus.out_wr_reg, tk[i], tg[i], wrx[i]);
            end
            if (ops[i] >= 5'd22) begin
                n_checks++;
                if (bus.out_result !== pcv[i] + 32'd4) begin
                    n_fail++;
                    $display("FAIL link[%0d]: result=%h required %h", i, bus.out_result, pcv[i] + 32'd4);
                end
            end
            tick();
            n_checks++;
            if (bus.br_taken !== 1'b0 || bus.out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL branch_pulse[%0d]: bt=%b valid=%b required bt=0 valid=0", i, bus.br_taken, bus.out_valid);
            end
        end
    endtask

    task automatic test_illegal();
        logic [4:0] ops [2] = '{5'd24, 5'd31};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            send(ops[i], 32'h11, 32'h22, 32'h0, 32'h0, 32'h0, 5'd7, 1'b1);
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_illegal !== 1'b1 || bus.out_result !== 32'h0 ||
                bus.out_wr_reg !== 1'b0 || bus.br_taken !== 1'b0) begin
                n_fail++;
                $display("FAIL illegal op%0d: valid=%b ill=%b res=%h wr=%b bt=%b, required 1 1 0 0 0",
                         ops[i], bus.out_valid, bus.out_illegal, bus.out_result, bus.out_wr_reg, bus.br_taken);
            end
        end
        tick();
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b0;
        send(5'd0, 32'd10, 32'd20, 32'h0, 32'h0, 32'h0, 5'd3, 1'b1);
        // A second instruction waits while the result is stalled
        bus.in_valid = 1'b1; bus.in_op = 5'd1; bus.in_a = 32'd100; bus.in_b = 32'd1;
        bus.in_rd = 5'd4; bus.in_wr_reg = 1'b1;
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_result !== 32'd30 || bus.out_rd !== 5'd3) begin
                n_fail++;
                $display("FAIL stall[%0d]: in_ready=%b valid=%b res=%0d rd=%0d, required 0 1 30 3",
                         k, bus.in_ready, bus.out_valid, bus.out_result, bus.out_rd);
            end
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL release_in_ready: got %b required 1", bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd99 || bus.out_rd !== 5'd4) begin
            n_fail++;
            $display("FAIL back_to_back: valid=%b res=%0d rd=%0d, required 1 99 4", bus.out_valid, bus.out_result, bus.out_rd);
        end
        tick();
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_drop: valid=%b required 0", bus.out_valid);
        end
    endtask

    task automatic test_reset_midway();
        bus.out_ready = 1'b0;
        send(5'd22, 32'h0, 32'h0, 32'h0, 32'h40, 32'h1000, 5'd1, 1'b1);
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_result !== 32'h1004 || bus.br_target !== 32'h1040) begin
            n_fail++;
            $display("FAIL held_jal: valid=%b res=%h tgt=%h, required 1 1004 1040", bus.out_valid, bus.out_result, bus.br_target);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.out_result !== 32'h0 || bus.out_rd !== 5'h0 || bus.out_wr_reg !== 1'b0 ||
            bus.br_target !== 32'h0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_held: valid=%b res=%h rd=%h wr=%b tgt=%h busy=%b in_ready=%b, required zeros and in_ready=1",
                     bus.out_valid, bus.out_result, bus.out_rd, bus.out_wr_reg, bus.br_target, bus.busy, bus.in_ready);
        end
    endtask

`ifdef AGEX_MDU_EN
    task automatic test_mdu();
        logic [4:0]  ops [14] = '{5'd12, 5'd14, 5'd13, 5'd15, 5'd12, 5'd14, 5'd10, 5'd11, 5'd12, 5'd14,
                                  5'd13, 5'd15, 5'd12, 5'd14};
        logic [31:0] av  [14] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'h1234, 32'h1234, 32'h80000000, 32'h80000000,
                                  32'h10001, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFF9, 32'd100, 32'd100, 32'd7, 32'd7};
        logic [31:0] bv  [14] = '{32'd2, 32'd2, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                  32'h10001, 32'hFFFFFFFF, 32'h0, 32'h0, 32'd7, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFE};
        logic [31:0] ex  [14] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1234, 32'h80000000, 32'h0,
                                  32'h00020001, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'd14, 32'd2, 32'hFFFFFFFD, 32'd1};
        int edges;
        int nbusy;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            send(ops[i], av[i], bv[i], 32'h0, 32'h0, 32'h0, 5'd5, 1'b1);
            n_checks++;
            if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL mdu_start[%0d]: busy=%b in_ready=%b valid=%b, required 1 0 0", i, bus.busy, bus.in_ready, bus.out_valid);
            end
            edges = 0;
            nbusy = 1;
            while (bus.out_valid !== 1'b1 && edges < 100) begin
                tick();
                edges++;
                if (bus.out_valid !== 1'b1 && bus.busy === 1'b1) nbusy++;
            end
            // accept cycle + 32 busy cycles: out_valid shows 32 edges after accept
            n_checks++;
            if (edges !== 32 || nbusy !== 32 || bus.out_result !== ex[i] || bus.busy !== 1'b0 || bus.out_wr_reg !== 1'b1) begin
                n_fail++;
                $display("FAIL mdu[%0d] op%0d: edges=%0d busy_cycles=%0d res=%h busy=%b wr=%b, required 32 32 %h 0 1",
                         i, ops[i], edges, nbusy, bus.out_result, bus.busy, bus.out_wr_reg, ex[i]);
            end
            tick();
            n_checks++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL mdu_drop[%0d]: valid=%b in_ready=%b, required 0 1", i, bus.out_valid, bus.in_ready);
            end
        end
    endtask

    task automatic test_mdu_reset();
        bus.out_ready = 1'b1;
        send(5'd10, 32'd3, 32'd5, 32'h0, 32'h0, 32'h0, 5'd2, 1'b1);
        repeat (8) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_result !== 32'h0) begin
            n_fail++;
            $display("FAIL mdu_reset: valid=%b busy=%b in_ready=%b res=%h, required 0 0 1 0",
                     bus.out_valid, bus.busy, bus.in_ready, bus.out_result);
        end
        repeat (40) tick();
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mdu_abandon: valid=%b required 0", bus.out_valid);
        end
    endtask
`else
    task automatic test_mdu_disabled();
        bus.out_ready = 1'b1;
        for (int op = 10; op <= 15; op++) begin
            send(5'(op), 32'd6, 32'd3, 32'h0, 32'h0, 32'h0, 5'd2, 1'b1);
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_illegal !== 1'b1 || bus.out_result !== 32'h0 ||
                bus.out_wr_reg !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL mdu_off op%0d: valid=%b ill=%b res=%h wr=%b busy=%b in_ready=%b, required 1 1 0 0 0 1",
                         op, bus.out_valid, bus.out_illegal, bus.out_result, bus.out_wr_reg, bus.busy, bus.in_ready);
            end
        end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_alu();
        test_branch();
        test_illegal();
        test_back_to_back();
        test_reset_midway();
`ifdef AGEX_MDU_EN
        test_mdu();
        test_mdu_reset();
`else
        test_mdu_disabled();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/agex_mdu_stage.md
Name: agex_mdu_stage

Overview:
- Parametrised execute stage: the successor to the single-cycle AGEX logic, generalised in datapath width.
- Adds a valid/ready handshake on both sides and back-pressure.
- Adds an iterative multicycle multiply/divide unit (MDU) next to the single-cycle ALU and branch resolver.
- Sits between decode (upstream) and memory (downstream). Drives the fetch redirect and the decode stall.

Parameters:
- XLEN, 32, datapath width in bits (must be ≥ 8 and a power of 2).
- REGNOBITS, 5, destination register index width.
- CNTBITS, 6, MDU iteration counter width (must satisfy 2^CNTBITS > XLEN).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  stage accepts the instruction this cycle.
- in_op  in  5  operation code (see Behaviour).
- in_a  in  XLEN  operand A (rs1 value).
- in_b  in  XLEN  operand B (rs2 value or immediate, already muxed by decode).
- in_rs2  in  XLEN  rs2 value, used for branch compares.
- in_imm  in  XLEN  sign-extended immediate, used for branch/jump targets.
- in_pc  in  XLEN  instruction PC.
- in_rd  in  REGNOBITS  destination register.
- in_wr_reg  in  1  instruction writes rd.
- out_valid  out  1  result is valid.
- out_ready  in  1  memory stage accepts the result.
- out_result  out  XLEN  ALU/MDU result or link address.
- out_rd  out  REGNOBITS  registered copy of in_rd.
- out_wr_reg  out  1  registered copy of in_wr_reg.
- out_illegal  out  1  the op code was unsupported.
- br_taken  out  1  one-cycle redirect pulse to fetch.
- br_target  out  XLEN  redirect PC.
- busy  out  1  MDU iterating; decode must stall.

Behaviour:
- Op codes, ALU ops (single cycle): 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU.
- Op codes, MDU ops (multicycle): 10 MUL (low XLEN bits), 11 MULHU, 12 DIV, 13 DIVU, 14 REM, 15 REMU.
- Op codes, branches and jumps: 16 BEQ, 17 BNE, 18 BLT, 19 BGE, 20 BLTU, 21 BGEU, 22 JAL, 23 JALR.
- Op codes 24–31 are illegal.
- Shift amounts use in_b[log2(XLEN)-1:0].
- FSM states: IDLE, BUSY, HOLD.
- in_ready = (state == IDLE) && (!out_valid || out_ready).
- Accept event = in_valid && in_ready.
- Non-MDU accept: the result, rd, wr_reg, illegal flag and branch outputs are registered. out_valid is asserted the next cycle. Latency is 1.
- MDU accept: IDLE→BUSY; busy=1; the counter is loaded with XLEN.
  - MUL/MULHU: shift-add, one bit per cycle, producing a 2·XLEN-bit product.
  - DIV family: restoring divide on magnitudes; signs are fixed up at the end for DIV/REM.
  - After XLEN iterations the FSM moves to HOLD; in HOLD out_valid=1 and busy=0.
  - HOLD→IDLE when out_ready=1.
  - Latency is XLEN+1 cycles from accept to out_valid.
- out_valid is held, with all out_* stable, until out_ready=1. It drops the cycle after the handshake unless a new accept occurs in that same cycle.
- Divide by zero: quotient = all ones; remainder = dividend.
- Signed overflow (-2^(XLEN-1) / -1): quotient = dividend; remainder = 0.
- Branches:
  - br_taken is registered with the result and asserted for exactly one cycle, the first cycle out_valid is high for that instruction.
  - Condition compares in_a against in_rs2, signed or unsigned as the op code requires.
  - Branch target = in_pc + in_imm.
  - JAL target = in_pc + in_imm; JALR target = (in_a + in_imm) with bit 0 cleared.
  - JAL/JALR out_result = in_pc + 4.
  - A not-taken branch gives br_taken=0 and out_wr_reg=0.
- Illegal op: out_result=0, out_illegal=1, out_wr_reg=0, latency 1.
- Arithmetic wraps modulo 2^XLEN; no flags are produced.
- Reset: state=IDLE. out_valid, out_result, out_rd, out_wr_reg, out_illegal, br_taken, br_target and busy are all 0.
  - Reset during BUSY abandons the operation; no output is produced.
- in_valid is ignored whenever in_ready=0; no input is captured.

Optional Feature:
- Macro AGEX_MDU_EN.
- When defined: the MDU is built and ops 10–15 behave as above.
- When undefined: the MDU logic is removed, ops 10–15 are treated as illegal (latency 1, out_illegal=1), and busy is tied to 0.

Test Plan:
1. ADD, in_a=0x7FFFFFFF, in_b=1, out_ready=1 → next cycle out_valid=1, out_result=0x80000000, latency 1.
2. DIV, in_a=-7, in_b=2 → busy high for 32 cycles, then out_result=0xFFFFFFFD (-3). REM of the same operands gives 0xFFFFFFFF (-1). Both take 33 cycles.
3. DIVU, in_b=0, in_a=0x1234 → out_result=0xFFFFFFFF; REMU with the same operands gives 0x1234. DIV 0x80000000 / -1 gives 0x80000000.
4. BNE, in_a=3, in_rs2=4, in_pc=0x100, in_imm=0x20 → br_taken pulses for 1 cycle with br_target=0x120. JALR, in_a=0x201, in_imm=0 → target 0x200, out_result=in_pc+4.
5. out_ready held 0 for 5 cycles after a result → out_valid and out_result stay stable and in_ready=0. Raising out_ready gives a handshake, and a back-to-back accept is possible in the same cycle.
6. reset pulsed in cycle 10 of a MUL → all outputs 0 and in_ready=1 the next cycle. With AGEX_MDU_EN undefined, op 10 → out_illegal=1 after 1 cycle.
